cnn_layer_sequencer: RTL

Hardware layer sequencer for the CNN accelerator. It replaces the CPU's per-layer program/start/poll loop. The CPU writes a per-layer descriptor table and the layer count, then pulses one start. The block then issues base addresses, the layer configuration word and a start pulse to the accelerator core for every layer in turn. It waits for each layer's done and advances the weight and parameter base addresses according to kernel type. It sits between the AHB register file and the accelerator core.

---
 rtl/cnn_layer_sequencer.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/cnn_layer_sequencer.sv
// cnn_layer_sequencer
//
// Walks a small per-layer descriptor table and drives the accelerator core
// through one layer after another: loads the base address and the layer
// configuration word, pulses layer_start, waits for layer_done, advances the
// weight/parameter bases by kernel type, idles for GAP_CYCLES, then moves on
// to the next layer. The CPU writes the table and the layer count, then
// pulses seq_start once.
//
// Optional feature macro: CNN_SEQ_TIMEOUT_EN enables a WAIT-state watchdog
// that raises the sticky seq_error after TIMEOUT_CYCLES without layer_done.
// Without it, WAIT waits indefinitely and seq_error is tied to 0.
//
// Ports:
//   HCLK, HRESETn          clock, asynchronous active-low reset
//   cfg_we/cfg_idx/cfg_wdata  descriptor write {act_shift[2:0], bias_shift[4:0], is_conv3x3};
//                          accepted only while idle
//   n_layer                layer count, latched at start and clamped to MAX_LAYER
//   seq_start, seq_abort   run request (level, sampled in idle) and abort
//   layer_done             accelerator layer complete (honoured only in WAIT)
//   base_addr              {param_base[11:0], weight_base[19:0]}
//   layer_config           {16'h0, act, bias, idx[3:0], is_last, is_conv3x3, is_last, is_first}
//   layer_start            one-cycle start pulse to the accelerator
//   cur_layer              index of the layer in flight
//   seq_busy/seq_done/seq_error  status (done and error are sticky)

module cnn_layer_sequencer #(
    parameter int unsigned MAX_LAYER      = 8,
    parameter int unsigned W_LIDX         = $clog2(MAX_LAYER),
    parameter int unsigned Ti             = 16,
    parameter int unsigned To             = 16,
    parameter int unsigned N              = 16,
    parameter int unsigned GAP_CYCLES     = 128,
    parameter int unsigned TIMEOUT_CYCLES = 1 << 20
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              cfg_we,
    input  logic [W_LIDX-1:0] cfg_idx,
    input  logic [8:0]        cfg_wdata,
    input  logic [W_LIDX:0]   n_layer,
    input  logic              seq_start,
    input  logic              seq_abort,
    input  logic              layer_done,
    output logic [31:0]       base_addr,
    output logic [31:0]       layer_config,
    output logic              layer_start,
    output logic [W_LIDX-1:0] cur_layer,
    output logic              seq_busy,
    output logic              seq_done,
    output logic              seq_error
);

    localparam logic [19:0]     WIncConv3 = 20'((Ti * To * 9) / N);
    localparam logic [19:0]     WIncConv1 = 20'(To);
    localparam logic [11:0]     PInc      = 12'(To);
    localparam int unsigned     GapW      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GapW-1:0] GapLast   = GapW'(GAP_CYCLES - 1);
    localparam logic [W_LIDX:0] MaxN      = (W_LIDX + 1)'(MAX_LAYER);
    localparam logic [W_LIDX:0] OneN      = (W_LIDX + 1)'(1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StStart,
        StWait,
        StGap
    } state_e;

    state_e              state_q, state_d;
    logic [W_LIDX-1:0]   idx_q, idx_d;
    logic [W_LIDX:0]     n_q, n_d;
    logic [19:0]         wbase_q, wbase_d;
    logic [11:0]         pbase_q, pbase_d;
    logic [GapW-1:0]     gap_cnt_q, gap_cnt_d;
    logic [31:0]         base_addr_q, base_addr_d;
    logic [31:0]         layer_config_q, layer_config_d;
    logic                layer_start_q, layer_start_d;
    logic [W_LIDX-1:0]   cur_layer_q, cur_layer_d;
    logic                done_q, done_d;
    logic [8:0]          desc_q [MAX_LAYER];

    logic                load_setup;
    logic                last_layer;
    logic [W_LIDX:0]     n_eff;

`ifdef CNN_SEQ_TIMEOUT_EN
    localparam int unsigned    ToW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT_CYCLES - 1);
    logic [ToW-1:0] to_cnt_q, to_cnt_d;
    logic           error_q, error_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    function automatic logic [31:0] make_config(input logic [8:0]        desc,
                                                input logic [W_LIDX-1:0] idx,
                                                input logic [W_LIDX:0]   n);
        logic is_first;
        logic is_last;
        is_first = (idx == '0);
        is_last  = ({1'b0, idx} == (n - OneN));
        return {16'h0, desc[8:1], 4'(idx), is_last, desc[0], is_last, is_first};
    endfunction

    assign last_layer = ({1'b0, idx_q} == (n_q - OneN));
    assign n_eff      = (n_layer > MaxN) ? MaxN : n_layer;

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        n_d            = n_q;
        wbase_d        = wbase_q;
        pbase_d        = pbase_q;
        gap_cnt_d      = gap_cnt_q;
        base_addr_d    = base_addr_q;
        layer_config_d = layer_config_q;
        layer_start_d  = 1'b0;
        cur_layer_d    = cur_layer_q;
        done_d         = done_q;
        load_setup     = 1'b0;
`ifdef CNN_SEQ_TIMEOUT_EN
        to_cnt_d       = to_cnt_q;
        error_d        = error_q;
`endif

        // Abort wins over everything else; outputs and sticky flags hold.
        if (seq_abort && (state_q != StIdle)) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (seq_start) begin
                        idx_d   = '0;
                        n_d     = n_eff;
                        wbase_d = '0;
                        pbase_d = '0;
                        done_d  = 1'b0;
`ifdef CNN_SEQ_TIMEOUT_EN
                        error_d = 1'b0;
`endif
                        if (n_eff == '0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d    = StSetup;
                            load_setup = 1'b1;
                        end
                    end
                end
                StSetup: begin
                    state_d       = StStart;
                    layer_start_d = 1'b1;
                end
                StStart: begin
                    state_d = StWait;
`ifdef CNN_SEQ_TIMEOUT_EN
                    to_cnt_d = '0;
`endif
                end
                StWait: begin
                    if (layer_done) begin
                        wbase_d   = wbase_q + (desc_q[idx_q][0] ? WIncConv3 : WIncConv1);
                        pbase_d   = pbase_q + PInc;
                        gap_cnt_d = '0;
                        state_d   = StGap;
                    end
`ifdef CNN_SEQ_TIMEOUT_EN
                    else if (to_cnt_q == ToLast) begin
                        error_d = 1'b1;
                        state_d = StIdle;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
`endif
                end
                StGap: begin
                    if (gap_cnt_q == GapLast) begin
                        if (last_layer) begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end else begin
                            idx_d      = idx_q + 1'b1;
                            state_d    = StSetup;
                            load_setup = 1'b1;
                        end
                    end else begin
                        gap_cnt_d = gap_cnt_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        // Outputs are registered on entry to SETUP so they are valid for the
        // whole SETUP cycle and hold until the next SETUP.
        if (load_setup) begin
            base_addr_d    = {pbase_d, wbase_d};
            layer_config_d = make_config(desc_q[idx_d], idx_d, n_d);
            cur_layer_d    = idx_d;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q        <= StIdle;
            idx_q          <= '0;
            n_q            <= '0;
            wbase_q        <= '0;
            pbase_q        <= '0;
            gap_cnt_q      <= '0;
            base_addr_q    <= '0;
            layer_config_q <= '0;
            layer_start_q  <= 1'b0;
            cur_layer_q    <= '0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            n_q            <= n_d;
            wbase_q        <= wbase_d;
            pbase_q        <= pbase_d;
            gap_cnt_q      <= gap_cnt_d;
            base_addr_q    <= base_addr_d;
            layer_config_q <= layer_config_d;
            layer_start_q  <= layer_start_d;
            cur_layer_q    <= cur_layer_d;
            done_q         <= done_d;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < int'(MAX_LAYER); i++) begin
                desc_q[i] <= '0;
            end
        end else if (cfg_we && (state_q == StIdle) && ({1'b0, cfg_idx} < MaxN)) begin
            desc_q[cfg_idx] <= cfg_wdata;
        end
    end

`ifdef CNN_SEQ_TIMEOUT_EN
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            to_cnt_q <= '0;
            error_q  <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            error_q  <= error_d;
        end
    end

    assign seq_error = error_q;
`else
    assign seq_error = 1'b0;
`endif

    assign base_addr    = base_addr_q;
    assign layer_config = layer_config_q;
    assign layer_start  = layer_start_q;
    assign cur_layer    = cur_layer_q;
    assign seq_busy     = (state_q != StIdle);
    assign seq_done     = done_q;

endmodule
